// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB arbiter: result packet layout and lane/FU counts.
package cdb_arbiter_pkg;

    localparam int WAYS       = 3;
    localparam int NUM_FU     = 5;
    localparam int XLEN       = 32;
    localparam int PRF        = 64;
    localparam int ROB        = 16;
    localparam int FIFO_DEPTH = 2;

    localparam int PRF_W  = $clog2(PRF);
    localparam int ROB_W  = $clog2(ROB);
    localparam int FU_W   = $clog2(NUM_FU);
    localparam int LANE_W = $clog2(WAYS);

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  data;
        logic [PRF_W-1:0] prf_idx;
        logic [ROB_W-1:0] rob_idx;
    } cdb_packet_t;

    // Next FU index in the round-robin scan, wrapping modulo NUM_FU.
    function automatic logic [FU_W-1:0] fu_wrap_inc(input logic [FU_W-1:0] i);
        return (i == FU_W'(NUM_FU - 1)) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU completion inputs and CDB broadcast outputs of the arbiter, bundled as one interface.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU-1:0][XLEN-1:0]  fu_data;
    logic [NUM_FU-1:0][PRF_W-1:0] fu_prf_idx;
    logic [NUM_FU-1:0][ROB_W-1:0] fu_rob_idx;
    logic [NUM_FU-1:0]            fu_ready;

    logic [WAYS-1:0]              CDB_valid;
    logic [WAYS-1:0][XLEN-1:0]    CDB_Data;
    logic [WAYS-1:0][PRF_W-1:0]   CDB_PRF_idx;
    logic [WAYS-1:0][ROB_W-1:0]   CDB_rob_idx;

    modport master (
        output fu_valid, fu_data, fu_prf_idx, fu_rob_idx,
        input  fu_ready, CDB_valid, CDB_Data, CDB_PRF_idx, CDB_rob_idx
    );

    modport slave (
        input  fu_valid, fu_data, fu_prf_idx, fu_rob_idx,
        output fu_ready, CDB_valid, CDB_Data, CDB_PRF_idx, CDB_rob_idx
    );

endinterface

// File: rtl/cdb_fu_fifo.sv
// Per-FU result buffer; ready depends only on the registered count, never on a same-cycle pop.
module cdb_fu_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        push,
    input  logic        pop,
    input  cdb_packet_t wr_pkt,
    output cdb_packet_t head,
    output logic        ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    cdb_packet_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign ready   = (count < FULL);
    assign do_push = push & ready;
    assign do_pop  = pop & (count != '0);

    always_ff @(posedge clock) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_pkt;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        head       = mem[rd_ptr];
        head.valid = (count != '0);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers FU results and grants up to WAYS of them per cycle onto the registered CDB lanes
// under rotating priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         squash,
    cdb_arbiter_if.slave bus
);

    logic                         clear;
    cdb_packet_t [NUM_FU-1:0]     wr_pkt;
    cdb_packet_t [NUM_FU-1:0]     head;
    logic [NUM_FU-1:0]            grant;
    logic [NUM_FU-1:0]            ready;
    logic [FU_W-1:0]              rr_ptr;
    logic [FU_W-1:0]              last_fu;
    int unsigned                  n_grant;
    int unsigned                  idx;

    logic [WAYS-1:0]              valid_n;
    logic [WAYS-1:0][XLEN-1:0]    data_n;
    logic [WAYS-1:0][PRF_W-1:0]   prf_n;
    logic [WAYS-1:0][ROB_W-1:0]   rob_n;

    assign clear = reset | squash;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        assign wr_pkt[i] = '{valid:   1'b1,
                             data:    bus.fu_data[i],
                             prf_idx: bus.fu_prf_idx[i],
                             rob_idx: bus.fu_rob_idx[i]};

        cdb_fu_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock  (clock),
            .clear  (clear),
            .push   (bus.fu_valid[i]),
            .pop    (grant[i]),
            .wr_pkt (wr_pkt[i]),
            .head   (head[i]),
            .ready  (ready[i])
        );
    end

    assign bus.fu_ready = ready;

    // Scan from rr_ptr; the k-th non-empty head lands on lane k so lanes fill without holes.
    always_comb begin
        grant   = '0;
        last_fu = rr_ptr;
        n_grant = 0;
        idx     = 0;
        valid_n = '0;
        data_n  = '0;
        prf_n   = '0;
        rob_n   = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (head[FU_W'(idx)].valid && (n_grant < WAYS)) begin
                grant[FU_W'(idx)]          = 1'b1;
                valid_n[LANE_W'(n_grant)]  = 1'b1;
                data_n[LANE_W'(n_grant)]   = head[FU_W'(idx)].data;
                prf_n[LANE_W'(n_grant)]    = head[FU_W'(idx)].prf_idx;
                rob_n[LANE_W'(n_grant)]    = head[FU_W'(idx)].rob_idx;
                last_fu                    = FU_W'(idx);
                n_grant                    = n_grant + 1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            rr_ptr          <= '0;
            bus.CDB_valid   <= '0;
            bus.CDB_Data    <= '0;
            bus.CDB_PRF_idx <= '0;
            bus.CDB_rob_idx <= '0;
        end else begin
            bus.CDB_valid   <= valid_n;
            bus.CDB_Data    <= data_n;
            bus.CDB_PRF_idx <= prf_n;
            bus.CDB_rob_idx <= rob_n;
            if (n_grant != 0) begin
                rr_ptr <= fu_wrap_inc(last_fu);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed vectors plus a per-FU sequence scoreboard.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic squash;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    int unsigned sent  [NUM_FU];
    int unsigned seen  [NUM_FU];
    int unsigned quota [NUM_FU];
    int unsigned gap   [NUM_FU];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] mk_data(input int unsigned fu, input int unsigned seq);
        return {fu[7:0], 8'h5A, seq[15:0]};
    endfunction

    function automatic logic [PRF_W-1:0] mk_prf(input int unsigned fu, input int unsigned seq);
        return PRF_W'((fu * 11 + seq) % 64);
    endfunction

    function automatic logic [ROB_W-1:0] mk_rob(input int unsigned fu, input int unsigned seq);
        return ROB_W'((fu + seq) % 16);
    endfunction

    task automatic idle_inputs();
        bus.fu_valid   = '0;
        bus.fu_data    = '0;
        bus.fu_prf_idx = '0;
        bus.fu_rob_idx = '0;
    endtask

    task automatic set_fu(input int unsigned i, input logic [XLEN-1:0] d,
                          input logic [PRF_W-1:0] p, input logic [ROB_W-1:0] r);
        bus.fu_valid[FU_W'(i)]   = 1'b1;
        bus.fu_data[FU_W'(i)]    = d;
        bus.fu_prf_idx[FU_W'(i)] = p;
        bus.fu_rob_idx[FU_W'(i)] = r;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            sent[i]  = 0;
            seen[i]  = 0;
            quota[i] = 0;
            gap[i]   = 0;
        end
    endtask

    // One scoreboarded cycle: consume the CDB, check ready against outstanding items, drive FUs.
    task automatic step(input bit chk_gap);
        logic [NUM_FU-1:0] rdy;
        logic [NUM_FU-1:0] exp_rdy;
        logic [NUM_FU-1:0] hit;
        logic [NUM_FU-1:0] drv;
        bit                hole;
        bit                packed_ok;
        int unsigned       fu;
        hole      = 1'b0;
        packed_ok = 1'b1;
        hit       = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (bus.CDB_valid[LANE_W'(w)]) begin
                if (hole) packed_ok = 1'b0;
                fu = 32'(bus.CDB_Data[LANE_W'(w)][31:24]);
                check("cdb_fu_range", 64'(fu < NUM_FU), 64'd1);
                if (fu < NUM_FU) begin
                    check("cdb_data", 64'(bus.CDB_Data[LANE_W'(w)]), 64'(mk_data(fu, seen[fu])));
                    check("cdb_prf", 64'(bus.CDB_PRF_idx[LANE_W'(w)]), 64'(mk_prf(fu, seen[fu])));
                    check("cdb_rob", 64'(bus.CDB_rob_idx[LANE_W'(w)]), 64'(mk_rob(fu, seen[fu])));
                    seen[fu]++;
                    hit[FU_W'(fu)] = 1'b1;
                end
            end else begin
                hole = 1'b1;
            end
        end
        check("lanes_packed", 64'(packed_ok), 64'd1);
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            gap[i] = hit[FU_W'(i)] ? 0 : gap[i] + 1;
            if (chk_gap) check("starve_gap", 64'(gap[i] <= 1), 64'd1);
            exp_rdy[FU_W'(i)] = ((sent[i] - seen[i]) < FIFO_DEPTH);
        end
        check("fu_ready", 64'(bus.fu_ready), 64'(exp_rdy));
        rdy = bus.fu_ready;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            drv[FU_W'(i)]            = (sent[i] < quota[i]);
            bus.fu_valid[FU_W'(i)]   = drv[FU_W'(i)];
            bus.fu_data[FU_W'(i)]    = mk_data(i, sent[i]);
            bus.fu_prf_idx[FU_W'(i)] = mk_prf(i, sent[i]);
            bus.fu_rob_idx[FU_W'(i)] = mk_rob(i, sent[i]);
        end
        tick();
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (drv[FU_W'(i)] && rdy[FU_W'(i)]) sent[i]++;
        end
    endtask

    initial begin
        squash = 1'b0;
        reset  = 1'b1;
        idle_inputs();

        // Reset held two cycles, then quiet bus.
        tick();
        tick();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check("t1_valid", 64'(bus.CDB_valid), 64'h0);
            check("t1_ready", 64'(bus.fu_ready), 64'h1f);
            check("t1_data0", 64'(bus.CDB_Data[0]), 64'h0);
            check("t1_data2", 64'(bus.CDB_Data[2]), 64'h0);
            tick();
        end

        // Single FU0 result: two-cycle latency, one cycle on lane 0.
        set_fu(0, 32'habc, 6'd4, 4'd3);
        tick();
        idle_inputs();
        check("t2_n1_valid", 64'(bus.CDB_valid), 64'h0);
        tick();
        check("t2_valid", 64'(bus.CDB_valid), 64'h1);
        check("t2_data", 64'(bus.CDB_Data[0]), 64'habc);
        check("t2_prf", 64'(bus.CDB_PRF_idx[0]), 64'd4);
        check("t2_rob", 64'(bus.CDB_rob_idx[0]), 64'd3);
        check("t2_data1", 64'(bus.CDB_Data[1]), 64'h0);
        tick();
        check("t2_n3_valid", 64'(bus.CDB_valid), 64'h0);

        // All five FUs at once from rr_ptr=0.
        do_reset();
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            set_fu(i, 32'ha0 + i, PRF_W'(10 + i), ROB_W'(i));
        end
        tick();
        idle_inputs();
        check("t3_n1_valid", 64'(bus.CDB_valid), 64'h0);
        tick();
        check("t3_b1_valid", 64'(bus.CDB_valid), 64'h7);
        check("t3_b1_d0", 64'(bus.CDB_Data[0]), 64'ha0);
        check("t3_b1_d1", 64'(bus.CDB_Data[1]), 64'ha1);
        check("t3_b1_d2", 64'(bus.CDB_Data[2]), 64'ha2);
        check("t3_b1_p2", 64'(bus.CDB_PRF_idx[2]), 64'd12);
        check("t3_b1_r1", 64'(bus.CDB_rob_idx[1]), 64'd1);
        tick();
        check("t3_b2_valid", 64'(bus.CDB_valid), 64'h3);
        check("t3_b2_d0", 64'(bus.CDB_Data[0]), 64'ha3);
        check("t3_b2_d1", 64'(bus.CDB_Data[1]), 64'ha4);
        check("t3_b2_p0", 64'(bus.CDB_PRF_idx[0]), 64'd13);
        check("t3_b2_r1", 64'(bus.CDB_rob_idx[1]), 64'd4);
        check("t3_b2_d2", 64'(bus.CDB_Data[2]), 64'h0);
        tick();
        check("t3_b3_valid", 64'(bus.CDB_valid), 64'h0);
        // rr_ptr back at 0: FU0 must take lane 0 ahead of FU4.
        set_fu(4, 32'hb4, 6'd20, 4'd5);
        set_fu(0, 32'hb0, 6'd21, 4'd6);
        tick();
        idle_inputs();
        tick();
        check("t3_rr_valid", 64'(bus.CDB_valid), 64'h3);
        check("t3_rr_d0", 64'(bus.CDB_Data[0]), 64'hb0);
        check("t3_rr_d1", 64'(bus.CDB_Data[1]), 64'hb4);

        // All FUs streaming for 20 cycles, then drain.
        do_reset();
        for (int unsigned i = 0; i < NUM_FU; i++) quota[i] = 1000;
        for (int s = 0; s < 20; s++) step(s >= 3);
        for (int unsigned i = 0; i < NUM_FU; i++) quota[i] = sent[i];
        for (int s = 0; s < 10; s++) step(1'b0);
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            check("t4_drained", 64'(seen[i]), 64'(sent[i]));
        end

        // FU2 fills behind streaming neighbours, stalls, and recovers after its first pop.
        do_reset();
        quota[0] = 6;
        quota[1] = 6;
        quota[3] = 6;
        quota[4] = 6;
        step(1'b0);
        quota[2] = 3;
        step(1'b0);
        check("t5_c2_ready2", 64'(bus.fu_ready[2]), 64'h1);
        step(1'b0);
        check("t5_c3_ready2", 64'(bus.fu_ready[2]), 64'h0);
        step(1'b0);
        check("t5_c4_ready2", 64'(bus.fu_ready[2]), 64'h1);
        for (int s = 0; s < 14; s++) step(1'b0);
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            check("t5_drained", 64'(seen[i]), 64'(quota[i]));
        end

        // Squash with a full CDB and a coincident push.
        do_reset();
        for (int unsigned i = 0; i < NUM_FU; i++) set_fu(i, 32'hc0 + i, 6'd1, 4'd1);
        tick();
        for (int unsigned i = 0; i < NUM_FU; i++) set_fu(i, 32'hd0 + i, 6'd2, 4'd2);
        tick();
        idle_inputs();
        check("t6_pre_valid", 64'(bus.CDB_valid), 64'h7);
        squash = 1'b1;
        set_fu(0, 32'hdead, 6'd63, 4'd15);
        tick();
        squash = 1'b0;
        idle_inputs();
        check("t6_valid", 64'(bus.CDB_valid), 64'h0);
        check("t6_ready", 64'(bus.fu_ready), 64'h1f);
        check("t6_data0", 64'(bus.CDB_Data[0]), 64'h0);
        check("t6_prf1", 64'(bus.CDB_PRF_idx[1]), 64'h0);
        check("t6_rob2", 64'(bus.CDB_rob_idx[2]), 64'h0);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("t6_quiet", 64'(bus.CDB_valid), 64'h0);
        end

        // Reset and squash together behave as either alone.
        set_fu(1, 32'h77, 6'd7, 4'd7);
        tick();
        idle_inputs();
        reset  = 1'b1;
        squash = 1'b1;
        tick();
        reset  = 1'b0;
        squash = 1'b0;
        check("t7_valid", 64'(bus.CDB_valid), 64'h0);
        check("t7_ready", 64'(bus.fu_ready), 64'h1f);
        tick();
        check("t7_quiet", 64'(bus.CDB_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
